// File: rtl/bypass_scoreboard_if.sv
// ID-to-bypass-network bundle: issue/lookup inputs plus the forwarding and hazard results.
interface bypass_scoreboard_if #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 5,
  parameter int unsigned RPORTS = 4,
  parameter int unsigned DW     = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned LW     = 3
) ();
  logic                       i_stall;
  logic                       i_flush;
  logic [LANES-1:0]           i_issue_vld;
  logic [LANES-1:0]           i_issue_we;
  logic [LANES*AW-1:0]        i_issue_waddr;
  logic [LANES*LW-1:0]        i_issue_lat;
  logic [STAGES*LANES*DW-1:0] i_stage_result;
  logic [RPORTS*AW-1:0]       i_raddr;
  logic [RPORTS-1:0]          o_bypass_vld;
  logic [RPORTS*DW-1:0]       o_bypass_data;
  logic [RPORTS-1:0]          o_hazard;
  logic                       o_stall_req;

  modport master (
    output i_stall, i_flush, i_issue_vld, i_issue_we, i_issue_waddr, i_issue_lat,
           i_stage_result, i_raddr,
    input  o_bypass_vld, o_bypass_data, o_hazard, o_stall_req
  );

  modport slave (
    input  i_stall, i_flush, i_issue_vld, i_issue_we, i_issue_waddr, i_issue_lat,
           i_stage_result, i_raddr,
    output o_bypass_vld, o_bypass_data, o_hazard, o_stall_req
  );
endinterface

// File: rtl/bypass_scoreboard.sv
// Dual-issue bypass network: tracks in-flight writes through an EX1..WB tag pipeline
// and forwards the youngest producer to each ID read port. Option: LA64_BYPASS_R0_FILTER_EN.
module bypass_scoreboard #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned STAGES = 5,
  parameter int unsigned RPORTS = 4,
  parameter int unsigned DW     = 64,
  parameter int unsigned AW     = 5,
  parameter int unsigned LW     = 3
) (
  input logic               i_clk,
  input logic               i_rst,
  bypass_scoreboard_if.slave bus
);

  localparam int unsigned NENT          = STAGES * LANES;
  localparam int unsigned IW            = (NENT > 1) ? $clog2(NENT) : 1;
  localparam logic [LW-1:0] REM_MAX     = LW'(STAGES - 1);
`ifdef LA64_BYPASS_R0_FILTER_EN
  localparam bit R0_FILTER = 1'b1;
`else
  localparam bit R0_FILTER = 1'b0;
`endif

  // Entry e = s*LANES + l holds the tag for stage s, lane l.
  logic [NENT-1:0] valid_q, valid_d;
  logic [AW-1:0]   waddr_q [NENT];
  logic [AW-1:0]   waddr_d [NENT];
  logic [LW-1:0]   rem_q   [NENT];
  logic [LW-1:0]   rem_d   [NENT];
  logic [DW-1:0]   result  [NENT];

  logic [RPORTS-1:0] sel_hit;
  logic [IW-1:0]     sel_idx [RPORTS];
  logic [RPORTS-1:0] bypass_vld;
  logic [RPORTS*DW-1:0] bypass_data;
  logic [RPORTS-1:0] hazard;

  function automatic logic [LW-1:0] clamp_lat(input logic [LW-1:0] lat);
    return (lat > REM_MAX) ? REM_MAX : lat;
  endfunction

  for (genvar g = 0; g < NENT; g++) begin : g_res
    assign result[g] = bus.i_stage_result[g*DW +: DW];
  end

  // Next tag-pipeline state: flush beats stall, stall freezes everything.
  always_comb begin
    valid_d = valid_q;
    waddr_d = waddr_q;
    rem_d   = rem_q;
    if (bus.i_flush) begin
      valid_d = '0;
    end else if (!bus.i_stall) begin
      for (int s = STAGES - 1; s > 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          valid_d[s*LANES+l] = valid_q[(s-1)*LANES+l];
          waddr_d[s*LANES+l] = waddr_q[(s-1)*LANES+l];
          rem_d[s*LANES+l]   = (rem_q[(s-1)*LANES+l] == '0) ? '0
                                 : rem_q[(s-1)*LANES+l] - LW'(1);
        end
      end
      for (int l = 0; l < LANES; l++) begin
        valid_d[l] = bus.i_issue_vld[l] & bus.i_issue_we[l];
        waddr_d[l] = bus.i_issue_waddr[l*AW +: AW];
        rem_d[l]   = clamp_lat(bus.i_issue_lat[l*LW +: LW]);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= '0;
      for (int e = 0; e < NENT; e++) begin
        waddr_q[e] <= '0;
        rem_q[e]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      waddr_q <= waddr_d;
      rem_q   <= rem_d;
    end
  end

  // Youngest-match select: scan oldest first so lower stage / higher lane overwrite.
  always_comb begin
    sel_hit = '0;
    for (int p = 0; p < RPORTS; p++) begin
      sel_idx[p] = '0;
      for (int s = STAGES - 1; s >= 0; s--) begin
        for (int l = 0; l < LANES; l++) begin
          if (valid_q[s*LANES+l] &&
              (waddr_q[s*LANES+l] == bus.i_raddr[p*AW +: AW]) &&
              !(R0_FILTER && (bus.i_raddr[p*AW +: AW] == '0))) begin
            sel_hit[p] = 1'b1;
            sel_idx[p] = IW'(s*LANES + l);
          end
        end
      end
    end
  end

  // A not-ready youngest producer blocks forwarding from any older entry.
  always_comb begin
    bypass_vld  = '0;
    bypass_data = '0;
    hazard      = '0;
    for (int p = 0; p < RPORTS; p++) begin
      if (sel_hit[p]) begin
        if (rem_q[sel_idx[p]] == '0) begin
          bypass_vld[p]            = 1'b1;
          bypass_data[p*DW +: DW]  = result[sel_idx[p]];
        end else begin
          hazard[p] = 1'b1;
        end
      end
    end
  end

  assign bus.o_bypass_vld  = bypass_vld;
  assign bus.o_bypass_data = bypass_data;
  assign bus.o_hazard      = hazard;
  assign bus.o_stall_req   = |hazard;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed table-driven bench for bypass_scoreboard plus reset and r0 sequences.
module tb_bypass_scoreboard;

  localparam int unsigned LANES  = 2;
  localparam int unsigned STAGES = 5;
  localparam int unsigned RPORTS = 4;
  localparam int unsigned DW     = 64;
  localparam int unsigned AW     = 5;
  localparam int unsigned LW     = 3;
  localparam int unsigned NENT   = STAGES * LANES;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  bypass_scoreboard_if #(.LANES(LANES), .STAGES(STAGES), .RPORTS(RPORTS),
                         .DW(DW), .AW(AW), .LW(LW)) bus ();

  bypass_scoreboard #(.LANES(LANES), .STAGES(STAGES), .RPORTS(RPORTS),
                      .DW(DW), .AW(AW), .LW(LW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vld;
    logic [1:0]  we;
    logic [9:0]  waddr;
    logic [5:0]  lat;
    logic        stall;
    logic        flush;
    logic [19:0] raddr;
    logic [3:0]  ev;
    logic [3:0]  eh;
    logic [15:0] eidx;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] we,
                              input logic [4:0] w0, input logic [4:0] w1,
                              input logic [2:0] l0, input logic [2:0] l1,
                              input logic st, input logic fl,
                              input logic [4:0] a0, input logic [4:0] a1,
                              input logic [4:0] a2, input logic [4:0] a3,
                              input logic [3:0] ev, input logic [3:0] eh,
                              input logic [3:0] i0, input logic [3:0] i1,
                              input logic [3:0] i2, input logic [3:0] i3);
    vec_t v;
    v.vld = vld; v.we = we; v.waddr = {w1, w0}; v.lat = {l1, l0};
    v.stall = st; v.flush = fl; v.raddr = {a3, a2, a1, a0};
    v.ev = ev; v.eh = eh; v.eidx = {i3, i2, i1, i0};
    return v;
  endfunction

  function automatic logic [63:0] pat(input int unsigned e);
    return 64'h0000_00A5_0000_0000 + 64'(e);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.i_stall       = 1'b0;
    bus.i_flush       = 1'b0;
    bus.i_issue_vld   = '0;
    bus.i_issue_we    = '0;
    bus.i_issue_waddr = '0;
    bus.i_issue_lat   = '0;
    bus.i_raddr       = '0;
  endtask

  task automatic check_ports(input string tag, input logic [3:0] ev, input logic [3:0] eh,
                             input logic [15:0] eidx);
    logic [63:0] ed;
    for (int p = 0; p < RPORTS; p++) begin
      ed = ev[p] ? pat(32'(eidx[p*4 +: 4])) : 64'd0;
      chk($sformatf("%s_vld%0d", tag, p), 64'(bus.o_bypass_vld[p]), 64'(ev[p]));
      chk($sformatf("%s_haz%0d", tag, p), 64'(bus.o_hazard[p]), 64'(eh[p]));
      chk($sformatf("%s_data%0d", tag, p), bus.o_bypass_data[p*DW +: DW], ed);
    end
    chk($sformatf("%s_stallreq", tag), 64'(bus.o_stall_req), 64'(|eh));
  endtask

  vec_t tbl [18];

  initial begin
    tbl[0]  = mk(2'b11, 2'b11, 5'd3, 5'd7, 3'd0, 3'd2, 0, 0, 5'd3, 5'd7, 5'd5, 5'd9, 4'b0000, 4'b0000, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[1]  = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd3, 5'd7, 5'd5, 5'd1, 4'b0001, 4'b0010, 4'd0, 4'hF, 4'hF, 4'hF);
    tbl[2]  = mk(2'b11, 2'b11, 5'd5, 5'd5, 3'd0, 3'd0, 0, 0, 5'd3, 5'd7, 5'd5, 5'd1, 4'b0001, 4'b0010, 4'd2, 4'hF, 4'hF, 4'hF);
    tbl[3]  = mk(2'b01, 2'b01, 5'd5, 5'd0, 3'd0, 3'd0, 0, 0, 5'd3, 5'd7, 5'd5, 5'd1, 4'b0111, 4'b0000, 4'd4, 4'd5, 4'd1, 4'hF);
    tbl[4]  = mk(2'b11, 2'b10, 5'd1, 5'd9, 3'd0, 3'd1, 0, 0, 5'd3, 5'd7, 5'd5, 5'd1, 4'b0111, 4'b0000, 4'd6, 4'd7, 4'd0, 4'hF);
    tbl[5]  = mk(2'b01, 2'b01, 5'd1, 5'd0, 3'd0, 3'd0, 1, 0, 5'd3, 5'd9, 5'd5, 5'd1, 4'b0101, 4'b0010, 4'd8, 4'hF, 4'd2, 4'hF);
    tbl[6]  = mk(2'b01, 2'b01, 5'd1, 5'd0, 3'd0, 3'd0, 1, 0, 5'd3, 5'd9, 5'd5, 5'd1, 4'b0101, 4'b0010, 4'd8, 4'hF, 4'd2, 4'hF);
    tbl[7]  = mk(2'b01, 2'b01, 5'd1, 5'd0, 3'd0, 3'd0, 1, 0, 5'd3, 5'd9, 5'd5, 5'd1, 4'b0101, 4'b0010, 4'd8, 4'hF, 4'd2, 4'hF);
    tbl[8]  = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd3, 5'd9, 5'd5, 5'd1, 4'b0101, 4'b0010, 4'd8, 4'hF, 4'd2, 4'hF);
    tbl[9]  = mk(2'b01, 2'b01, 5'd4, 5'd0, 3'd3, 3'd0, 0, 0, 5'd3, 5'd9, 5'd5, 5'd1, 4'b0110, 4'b0000, 4'hF, 4'd3, 4'd4, 4'hF);
    tbl[10] = mk(2'b10, 2'b10, 5'd0, 5'd2, 3'd0, 3'd0, 1, 1, 5'd4, 5'd9, 5'd5, 5'd1, 4'b0110, 4'b0001, 4'hF, 4'd5, 4'd6, 4'hF);
    tbl[11] = mk(2'b01, 2'b01, 5'd6, 5'd0, 3'd7, 3'd0, 0, 0, 5'd4, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0000, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[12] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0001, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[13] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0001, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[14] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0001, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[15] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0001, 4'hF, 4'hF, 4'hF, 4'hF);
    tbl[16] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0001, 4'b0000, 4'd8, 4'hF, 4'hF, 4'hF);
    tbl[17] = mk(2'b00, 2'b00, 5'd0, 5'd0, 3'd0, 3'd0, 0, 0, 5'd6, 5'd9, 5'd5, 5'd2, 4'b0000, 4'b0000, 4'hF, 4'hF, 4'hF, 4'hF);

    rst = 1'b1;
    idle_inputs();
    for (int e = 0; e < NENT; e++) bus.i_stage_result[e*DW +: DW] = pat(e);
    tick();
    tick();
    rst = 1'b0;

    // Each record: drive inputs, check outputs of the current state, then clock.
    for (int i = 0; i < 18; i++) begin
      bus.i_issue_vld   = tbl[i].vld;
      bus.i_issue_we    = tbl[i].we;
      bus.i_issue_waddr = tbl[i].waddr;
      bus.i_issue_lat   = tbl[i].lat;
      bus.i_stall       = tbl[i].stall;
      bus.i_flush       = tbl[i].flush;
      bus.i_raddr       = tbl[i].raddr;
      #2;
      check_ports($sformatf("rec%0d", i), tbl[i].ev, tbl[i].eh, tbl[i].eidx);
      tick();
    end

    // Reset mid-operation removes a pending hazard on the next cycle.
    idle_inputs();
    bus.i_issue_vld   = 2'b01;
    bus.i_issue_we    = 2'b01;
    bus.i_issue_waddr = {5'd0, 5'd4};
    bus.i_issue_lat   = {3'd0, 3'd3};
    tick();
    idle_inputs();
    bus.i_raddr = {5'd1, 5'd1, 5'd1, 5'd4};
    #2;
    check_ports("rstpre", 4'b0000, 4'b0001, 16'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    check_ports("rstpost", 4'b0000, 4'b0000, 16'hFFFF);

    // r0 write followed by an r0 read.
    bus.i_issue_vld   = 2'b01;
    bus.i_issue_we    = 2'b01;
    bus.i_issue_waddr = '0;
    bus.i_issue_lat   = '0;
    tick();
    idle_inputs();
    bus.i_raddr = {5'd1, 5'd1, 5'd1, 5'd0};
    #2;
`ifdef LA64_BYPASS_R0_FILTER_EN
    check_ports("r0", 4'b0000, 4'b0000, 16'hFFFF);
`else
    check_ports("r0", 4'b0001, 4'b0000, 16'hFFF0);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
